// File: rtl/breadboard.sv
// Four-way intersection traffic-light controller: day rotation, night service, pedestrian and emergency phases.
// Optional NIGHT_ADAPTIVE_EN: night mode serves the direction with the most queued cars.
module breadboard #(
  parameter int DAY_TIME   = 20,
  parameter int NIGHT_TIME = 10,
  parameter int PED_TIME   = 15,
  parameter int EMG_TIME   = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] lanes,
  output logic [7:0]  carLights,
  output logic [7:0]  walkLights,
  output logic [1:0]  trafficMode,
  output logic        dayNight,
  output logic [6:0]  currentCount
);

  typedef enum logic [1:0] {
    MODE_DAY   = 2'b00,
    MODE_NIGHT = 2'b01,
    MODE_PED   = 2'b10,
    MODE_EMG   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  localparam logic [6:0] DAY_LD   = 7'(DAY_TIME);
  localparam logic [6:0] NIGHT_LD = 7'(NIGHT_TIME);
  localparam logic [6:0] PED_LD   = 7'(PED_TIME);
  localparam logic [6:0] EMG_LD   = 7'(EMG_TIME);

  mode_e      mode_q, mode_d;
  dir_e       dir_q, dir_d;
  logic [6:0] cnt_q, cnt_d;
  logic [7:0] car_q, car_d;
  logic [7:0] walk_q, walk_d;
  logic       ped_q, ped_d;

  logic       is_zero;
  logic       emg_req;
  logic       ped_pend;
  dir_e       emg_sel;
  dir_e       night_dir;

  function automatic logic [7:0] dir_lights(input dir_e d);
    case (d)
      DIR_N:   dir_lights = 8'b0000_0011;
      DIR_E:   dir_lights = 8'b0000_1100;
      DIR_S:   dir_lights = 8'b0011_0000;
      default: dir_lights = 8'b1100_0000;
    endcase
  endfunction

  function automatic dir_e next_dir(input dir_e d);
    logic [1:0] t;
    t = d;
    next_dir = dir_e'(t + 2'd1);
  endfunction

  // Lowest set lane bit decides; checking lane pairs from bit 0 upward is equivalent.
  function automatic dir_e lane_dir(input logic [7:0] lane);
    if (|lane[1:0])      lane_dir = DIR_N;
    else if (|lane[3:2]) lane_dir = DIR_E;
    else if (|lane[5:4]) lane_dir = DIR_S;
    else                 lane_dir = DIR_W;
  endfunction

  assign dayNight = (hoursIn >= 5'd6) && (hoursIn <= 5'd17);
  assign is_zero  = (cnt_q == 7'd0);
  assign emg_req  = emgSignal && (|emgLane);
  assign ped_pend = ped_q | pedSignal;
  assign emg_sel  = lane_dir(emgLane);

`ifdef NIGHT_ADAPTIVE_EN
  logic [8:0] sum_n, sum_e, sum_s, sum_w, best_sum;
  dir_e       best_dir;

  // Strict comparisons keep ties on the earlier direction (N > E > S > W).
  always_comb begin
    sum_n    = {1'b0, lanes[63:56]} + {1'b0, lanes[55:48]};
    sum_e    = {1'b0, lanes[47:40]} + {1'b0, lanes[39:32]};
    sum_s    = {1'b0, lanes[31:24]} + {1'b0, lanes[23:16]};
    sum_w    = {1'b0, lanes[15:8]}  + {1'b0, lanes[7:0]};
    best_sum = sum_n;
    best_dir = DIR_N;
    if (sum_e > best_sum) begin
      best_sum = sum_e;
      best_dir = DIR_E;
    end
    if (sum_s > best_sum) begin
      best_sum = sum_s;
      best_dir = DIR_S;
    end
    if (sum_w > best_sum) begin
      best_sum = sum_w;
      best_dir = DIR_W;
    end
    night_dir = (best_sum != 9'd0) ? best_dir : next_dir(dir_q);
  end
`else
  logic unused_lanes;
  assign unused_lanes = ^lanes;
  assign night_dir    = next_dir(dir_q);
`endif

  // Emergency preempts any phase except a running emergency, which only reloads at zero.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    car_d  = car_q;
    walk_d = walk_q;
    ped_d  = ped_pend;
    cnt_d  = is_zero ? cnt_q : cnt_q - 7'd1;
    if (emg_req && ((mode_q != MODE_EMG) || is_zero)) begin
      mode_d = MODE_EMG;
      dir_d  = emg_sel;
      car_d  = dir_lights(emg_sel);
      walk_d = 8'h00;
      cnt_d  = EMG_LD;
    end else if (is_zero) begin
      if (ped_pend) begin
        mode_d = MODE_PED;
        car_d  = 8'h00;
        walk_d = 8'hFF;
        cnt_d  = PED_LD;
        ped_d  = 1'b0;
      end else if (dayNight) begin
        mode_d = MODE_DAY;
        dir_d  = next_dir(dir_q);
        car_d  = dir_lights(next_dir(dir_q));
        walk_d = 8'h00;
        cnt_d  = DAY_LD;
      end else begin
        mode_d = MODE_NIGHT;
        dir_d  = night_dir;
        car_d  = dir_lights(night_dir);
        walk_d = 8'h00;
        cnt_d  = NIGHT_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_DAY;
      dir_q  <= DIR_W;
      cnt_q  <= 7'd0;
      car_q  <= 8'h00;
      walk_q <= 8'h00;
      ped_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      car_q  <= car_d;
      walk_q <= walk_d;
      ped_q  <= ped_d;
    end
  end

  assign carLights    = car_q;
  assign walkLights   = walk_q;
  assign trafficMode  = mode_q;
  assign currentCount = cnt_q;

endmodule

// File: tb/tb_breadboard.sv
// Directed bench for the breadboard traffic-light controller (default timing parameters).
module tb_breadboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] lanes;
  logic [7:0]  carLights;
  logic [7:0]  walkLights;
  logic [1:0]  trafficMode;
  logic        dayNight;
  logic [6:0]  currentCount;

  int n_cmp  = 0;
  int n_fail = 0;

  breadboard dut (
    .clk          (clk),
    .rst          (rst),
    .hoursIn      (hoursIn),
    .pedSignal    (pedSignal),
    .emgSignal    (emgSignal),
    .emgLane      (emgLane),
    .lanes        (lanes),
    .carLights    (carLights),
    .walkLights   (walkLights),
    .trafficMode  (trafficMode),
    .dayNight     (dayNight),
    .currentCount (currentCount)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] mode, input logic [7:0] car,
                         input logic [7:0] walk, input logic [6:0] cnt);
    chk({tag, ".mode"}, {6'd0, trafficMode}, {6'd0, mode});
    chk({tag, ".car"},  carLights, car);
    chk({tag, ".walk"}, walkLights, walk);
    chk({tag, ".cnt"},  {1'b0, currentCount}, {1'b0, cnt});
  endtask

  localparam logic [7:0] N_G = 8'b0000_0011;
  localparam logic [7:0] E_G = 8'b0000_1100;
  localparam logic [7:0] S_G = 8'b0011_0000;
  localparam logic [7:0] W_G = 8'b1100_0000;

  logic [7:0] night_after_s;
  logic [7:0] night_after_rst;

  initial begin
`ifdef NIGHT_ADAPTIVE_EN
    night_after_s   = S_G;
    night_after_rst = S_G;
`else
    night_after_s   = W_G;
    night_after_rst = N_G;
`endif
    rst       = 1'b0;
    hoursIn   = 5'd12;
    pedSignal = 1'b0;
    emgSignal = 1'b0;
    emgLane   = 8'h00;
    lanes     = 64'd0;
    #1;
    chk_all("reset", 2'b00, 8'h00, 8'h00, 7'd0);
    chk("reset.dayNight", {7'd0, dayNight}, 8'd1);
    tick(2);
    chk_all("reset_held", 2'b00, 8'h00, 8'h00, 7'd0);
    rst = 1'b1;

    tick(1);
    chk_all("first_day_N", 2'b00, N_G, 8'h00, 7'd20);
    tick(20);
    chk_all("N_end", 2'b00, N_G, 8'h00, 7'd0);
    tick(1);
    chk_all("rot_E", 2'b00, E_G, 8'h00, 7'd20);

    emgSignal = 1'b1;
    emgLane   = 8'b0000_1000;
    pedSignal = 1'b1;
    tick(1);
    pedSignal = 1'b0;
    chk_all("emg_preempt", 2'b11, E_G, 8'h00, 7'd25);
    tick(25);
    chk_all("emg_zero", 2'b11, E_G, 8'h00, 7'd0);
    tick(1);
    chk_all("emg_reload", 2'b11, E_G, 8'h00, 7'd25);
    emgSignal = 1'b0;
    emgLane   = 8'h00;
    tick(25);
    chk_all("emg_end", 2'b11, E_G, 8'h00, 7'd0);
    tick(1);
    chk_all("ped_after_emg", 2'b10, 8'h00, 8'hFF, 7'd15);
    tick(15);
    chk_all("ped_end", 2'b10, 8'h00, 8'hFF, 7'd0);
    tick(1);
    chk_all("rot_S", 2'b00, S_G, 8'h00, 7'd20);

    tick(3);
    pedSignal = 1'b1;
    tick(1);
    pedSignal = 1'b0;
    chk_all("ped_pulse_nopreempt", 2'b00, S_G, 8'h00, 7'd16);
    tick(16);
    chk_all("S_end", 2'b00, S_G, 8'h00, 7'd0);
    tick(1);
    chk_all("ped_phase", 2'b10, 8'h00, 8'hFF, 7'd15);
    tick(15);
    chk_all("ped2_end", 2'b10, 8'h00, 8'hFF, 7'd0);
    tick(1);
    chk_all("rot_W", 2'b00, W_G, 8'h00, 7'd20);

    emgSignal = 1'b1;
    emgLane   = 8'b1010_0000;
    hoursIn   = 5'd22;
    lanes     = 64'd0;
    lanes[31:24] = 8'd127;
    lanes[63:56] = 8'd7;
    tick(1);
    chk_all("emg_lowbit_S", 2'b11, S_G, 8'h00, 7'd25);
    emgSignal = 1'b0;
    emgLane   = 8'h00;
    tick(25);
    chk("emg2_zero.cnt", {1'b0, currentCount}, 8'd0);
    tick(1);
    chk_all("night_phase", 2'b01, night_after_s, 8'h00, 7'd10);

    emgSignal = 1'b1;
    emgLane   = 8'h00;
    tick(1);
    chk_all("emg_nolane_ignored", 2'b01, night_after_s, 8'h00, 7'd9);
    emgSignal = 1'b0;

    rst = 1'b0;
    #1;
    chk_all("async_reset", 2'b00, 8'h00, 8'h00, 7'd0);
    tick(2);
    chk_all("reset_hold2", 2'b00, 8'h00, 8'h00, 7'd0);
    rst = 1'b1;
    tick(1);
    chk_all("night_after_rst", 2'b01, night_after_rst, 8'h00, 7'd10);

    hoursIn = 5'd5;  #1; chk("dn_5",  {7'd0, dayNight}, 8'd0);
    hoursIn = 5'd6;  #1; chk("dn_6",  {7'd0, dayNight}, 8'd1);
    hoursIn = 5'd17; #1; chk("dn_17", {7'd0, dayNight}, 8'd1);
    hoursIn = 5'd18; #1; chk("dn_18", {7'd0, dayNight}, 8'd0);
    hoursIn = 5'd24; #1; chk("dn_24", {7'd0, dayNight}, 8'd0);
    hoursIn = 5'd31; #1; chk("dn_31", {7'd0, dayNight}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
